regfile_ctrl: RTL and testbench

Multi-cycle operand-fetch / execute / write-back sequencer that drives the 8x16 register file's read port (readnum/data_out) and write port (writenum/write/data_in). It is the initiator side of the register-file interface. It accepts one register-to-register instruction through a valid/ready handshake, reads up to two source registers over successive cycles, computes a result, and commits it with a single write pulse.

---
 rtl/regfile_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_regfile_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: operand-fetch / execute / write-back sequencer driving the
// read and write ports of an 8x16 register file.
// One request is taken through a valid/ready handshake in IDLE, up to two
// source registers are read on successive cycles (RDA, RDB), the result is
// computed in EXEC, and it is committed with a single write pulse in WB.
// Optional feature macro: REGFILE_CTRL_SHIFT_EN adds req_shift[1:0], which
// selects a combinational shift of operand B ahead of EXEC.
module regfile_ctrl #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_rd,
    input  logic [AW-1:0] req_rn,
    input  logic [AW-1:0] req_rm,
    input  logic [W-1:0]  req_imm,
`ifdef REGFILE_CTRL_SHIFT_EN
    input  logic [1:0]    req_shift,
`endif
    output logic [AW-1:0] rf_readnum,
    input  logic [W-1:0]  rf_data_out,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [W-1:0]  rf_data_in,
    output logic [W-1:0]  result,
    output logic          z_flag,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_rn;
    logic [AW-1:0]   r_rm;
    logic [W-1:0]    r_imm;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_ready;
    logic            r_write;
    logic            r_done;
    logic [W-1:0]    r_result;
    logic            r_z;
    logic [AW-1:0]   r_last_readnum;
`ifdef REGFILE_CTRL_SHIFT_EN
    logic [1:0]      r_shift;
`endif

    logic [AW-1:0]   w_readnum;
    logic [W-1:0]    w_b_eff;
    logic [W-1:0]    w_exec_val;

    // Read address: source A in RDA, source B in RDB, otherwise the last value driven.
    always_comb begin
        w_readnum = r_last_readnum;
        case (r_state)
            S_RDA:   w_readnum = r_rn;
            S_RDB:   w_readnum = r_rm;
            default: w_readnum = r_last_readnum;
        endcase
    end

`ifdef REGFILE_CTRL_SHIFT_EN
    // Operand B after the optional one-bit shift (left, logical right, arithmetic right).
    always_comb begin
        w_b_eff = r_b;
        case (r_shift)
            2'b01:   w_b_eff = {r_b[W-2:0], 1'b0};
            2'b10:   w_b_eff = {1'b0, r_b[W-1:1]};
            2'b11:   w_b_eff = {r_b[W-1], r_b[W-1:1]};
            default: w_b_eff = r_b;
        endcase
    end
`else
    // Operand B is used as read from the register file.
    always_comb begin
        w_b_eff = r_b;
    end
`endif

    // Execute-stage result; ADD discards the carry by truncation to W bits.
    always_comb begin
        w_exec_val = '0;
        case (r_op)
            OP_MOV:  w_exec_val = r_imm;
            OP_ADD:  w_exec_val = r_a + w_b_eff;
            OP_AND:  w_exec_val = r_a & w_b_eff;
            OP_MVN:  w_exec_val = ~w_b_eff;
            default: w_exec_val = '0;
        endcase
    end

    // Sequencer: handshake, operand capture, result/flag update and the registered
    // ready/write/done strobes, all advanced together so they stay consistent with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_op           <= '0;
            r_rd           <= '0;
            r_rn           <= '0;
            r_rm           <= '0;
            r_imm          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_ready        <= 1'b1;
            r_write        <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_z            <= 1'b0;
            r_last_readnum <= '0;
`ifdef REGFILE_CTRL_SHIFT_EN
            r_shift        <= '0;
`endif
        end else begin
            r_write        <= 1'b0;
            r_done         <= 1'b0;
            r_last_readnum <= w_readnum;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_op    <= req_op;
                        r_rd    <= req_rd;
                        r_rn    <= req_rn;
                        r_rm    <= req_rm;
                        r_imm   <= req_imm;
`ifdef REGFILE_CTRL_SHIFT_EN
                        r_shift <= req_shift;
`endif
                        r_ready <= 1'b0;
                        case (req_op)
                            OP_MOV:  r_state <= S_EXEC;
                            OP_MVN:  r_state <= S_RDB;
                            default: r_state <= S_RDA;
                        endcase
                    end
                end
                S_RDA: begin
                    r_a     <= rf_data_out;
                    r_state <= S_RDB;
                end
                S_RDB: begin
                    r_b     <= rf_data_out;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_exec_val;
                    r_z      <= (w_exec_val == '0);
                    r_write  <= 1'b1;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_ready;
    assign rf_readnum  = w_readnum;
    assign rf_writenum = r_rd;
    assign rf_write    = r_write;
    assign rf_data_in  = r_result;
    assign result      = r_result;
    assign z_flag      = r_z;
    assign done        = r_done;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: bench for regfile_ctrl with an attached 8x16 register file,
// a cycle-level reference model, directed scenarios and a randomized phase.
module tb_regfile_ctrl;
    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_rd, req_rn, req_rm;
    logic [W-1:0]  req_imm;
`ifdef REGFILE_CTRL_SHIFT_EN
    logic [1:0]    req_shift;
`endif
    logic [AW-1:0] rf_readnum, rf_writenum;
    logic [W-1:0]  rf_data_out, rf_data_in, result;
    logic          rf_write, z_flag, done;

    always #5 clk = ~clk;

    regfile_ctrl #(.W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
        .req_imm(req_imm),
`ifdef REGFILE_CTRL_SHIFT_EN
        .req_shift(req_shift),
`endif
        .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
        .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
        .result(result), .z_flag(z_flag), .done(done)
    );

    // Attached register file: combinational read, write on the clock edge.
    logic [W-1:0] rf_mem [8];
    assign rf_data_out = rf_mem[rf_readnum];
    always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     cyc = 0;
    bit     pend = 0;
    int     acc, lat;
    int     m_op, m_rd, m_rn, m_rm, m_val;
    int     ref_rf [8];
    int     exp_result = 0;
    int     exp_z = 0;
    int     write_count = 0;
    bit     e_ready, e_write, e_done;
    int     ma, mb, msh;

    // Per-cycle compare: outputs must follow the request timeline of the last accept.
    always @(negedge clk) begin
        cyc++;
        if (rf_write === 1'b1) write_count++;
        if (reset) begin
            pend = 0; exp_result = 0; exp_z = 0;
            check("rst_ready",    32'(req_ready), 32'd1);
            check("rst_write",    32'(rf_write), 32'd0);
            check("rst_done",     32'(done), 32'd0);
            check("rst_result",   32'(result), 32'd0);
            check("rst_z",        32'(z_flag), 32'd0);
            check("rst_readnum",  32'(rf_readnum), 32'd0);
            check("rst_writenum", 32'(rf_writenum), 32'd0);
        end else begin
            e_write = pend && (cyc == acc + lat - 1);
            e_done  = pend && (cyc == acc + lat);
            e_ready = !pend || (cyc >= acc + lat);
            if (e_write) begin
                exp_result = m_val;
                exp_z = (m_val == 0) ? 1 : 0;
                ref_rf[m_rd] = m_val;
            end
            check("ready",   32'(req_ready), 32'(e_ready));
            check("write",   32'(rf_write), 32'(e_write));
            check("done",    32'(done), 32'(e_done));
            check("result",  32'(result), exp_result);
            check("z_flag",  32'(z_flag), exp_z);
            check("data_in", 32'(rf_data_in), exp_result);
            if (e_write) check("writenum", 32'(rf_writenum), m_rd);
            if (pend && cyc == acc + 1 && (m_op == 1 || m_op == 2))
                check("readnum_a", 32'(rf_readnum), m_rn);
            if (pend && cyc == acc + 1 && m_op == 3)
                check("readnum_b", 32'(rf_readnum), m_rm);
            if (pend && cyc == acc + 2 && (m_op == 1 || m_op == 2))
                check("readnum_b", 32'(rf_readnum), m_rm);
            if (e_ready && req_valid === 1'b1) begin
                acc = cyc; pend = 1;
                m_op = int'(req_op); m_rd = int'(req_rd);
                m_rn = int'(req_rn); m_rm = int'(req_rm);
                ma = ref_rf[m_rn]; mb = ref_rf[m_rm];
                msh = 0;
`ifdef REGFILE_CTRL_SHIFT_EN
                msh = int'(req_shift);
`endif
                if (msh == 1) mb = (mb * 2) % 65536;
                else if (msh == 2) mb = mb / 2;
                else if (msh == 3) mb = mb / 2 + ((mb >= 32768) ? 32768 : 0);
                case (m_op)
                    0: begin m_val = int'(req_imm); lat = 3; end
                    1: begin m_val = (ma + mb) % 65536; lat = 5; end
                    2: begin m_val = ma & mb; lat = 5; end
                    default: begin m_val = 65535 - mb; lat = 4; end
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int g = 0;
        while (req_ready !== 1'b1 && g < 40) begin
            @(posedge clk); #1; g++;
        end
        vectors++;
        if (g >= 40) begin
            miscompares++;
            $display("FAIL wait_ready: req_ready still %b after %0d cycles, expected 1", req_ready, g);
        end
    endtask

    task automatic set_req(input int op, input int rd, input int rn, input int rm,
                           input int imm, input int sh);
        req_op = 2'(op); req_rd = 3'(rd); req_rn = 3'(rn); req_rm = 3'(rm);
        req_imm = 16'(imm);
`ifdef REGFILE_CTRL_SHIFT_EN
        req_shift = 2'(sh);
`else
        if (sh != 0) $display("note: shift %0d ignored in this build", sh);
`endif
    endtask

    task automatic send(input int op, input int rd, input int rn, input int rm,
                        input int imm, input int sh);
        wait_ready();
        set_req(op, rd, rn, rm, imm, sh);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    int wc0;

    initial begin
        reset = 1'b1; req_valid = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: MOV timing pinned by hand
        send(0, 3, 0, 0, 'h00AB, 0);
        @(posedge clk); #1;
        check("t1_write",    32'(rf_write), 32'd1);
        check("t1_writenum", 32'(rf_writenum), 32'd3);
        check("t1_data_in",  32'(rf_data_in), 32'h00AB);
        @(posedge clk); #1;
        check("t1_done", 32'(done), 32'd1);
        check("t1_z",    32'(z_flag), 32'd0);
        check("t1_r3",   32'(rf_mem[3]), 32'h00AB);

        for (int i = 0; i < 8; i++) send(0, i, 0, 0, int'($urandom_range(0, 65535)), 0);

        // 2: overflow into the sign bit
        send(0, 1, 0, 0, 'h7FFF, 0);
        send(0, 2, 0, 0, 'h0001, 0);
        send(1, 0, 1, 2, 0, 0);
        wait_ready();
        check("t2_r0", 32'(rf_mem[0]), 32'h8000);

        // 3: wrap-around to zero, then AND
        send(0, 1, 0, 0, 'hFFFF, 0);
        send(1, 5, 1, 2, 0, 0);
        wait_ready();
        check("t3_r5", 32'(rf_mem[5]), 32'h0000);
        check("t3_z",  32'(z_flag), 32'd1);
        send(2, 6, 1, 2, 0, 0);
        wait_ready();
        check("t3_r6",  32'(rf_mem[6]), 32'h0001);
        check("t3_z2",  32'(z_flag), 32'd0);

        // 4: MVN with rd == rm
        send(0, 4, 0, 0, 'h00FF, 0);
        send(3, 4, 0, 4, 0, 0);
        wait_ready();
        check("t4_r4", 32'(rf_mem[4]), 32'hFF00);
`ifdef REGFILE_CTRL_SHIFT_EN
        send(0, 3, 0, 0, 'h8000, 0);
        send(3, 2, 0, 3, 0, 3);
        wait_ready();
        check("t4_shift", 32'(rf_mem[2]), 32'h3FFF);
        send(0, 2, 0, 0, 'h0001, 0);
`endif

        // 5: reset during RDB discards the ADD
        send(0, 7, 0, 0, 'h1234, 0);
        wait_ready();
        wc0 = write_count;
        send(1, 7, 1, 2, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_ready", 32'(req_ready), 32'd1);
        repeat (6) @(posedge clk); #1;
        check("t5_r7",     32'(rf_mem[7]), 32'h1234);
        check("t5_writes", 32'(write_count - wc0), 32'd0);

        // 6: held valid, ignored pulse while busy, back-to-back accept
        wait_ready();
        wc0 = write_count;
        set_req(0, 1, 0, 0, 'h0011, 0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        set_req(0, 5, 0, 0, 'hDEAD, 0);
        @(posedge clk); #1;
        set_req(1, 2, 1, 1, 0, 0);
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_ready();
        repeat (3) @(posedge clk); #1;
        check("t6_writes", 32'(write_count - wc0), 32'd2);
        check("t6_r2",     32'(rf_mem[2]), 32'h0022);
        check("t6_r5",     32'(rf_mem[5]), 32'h0000);

        // randomized phase: fresh inputs every cycle, occasional reset
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            req_valid = $urandom_range(0, 1) == 1;
            set_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535)),
`ifdef REGFILE_CTRL_SHIFT_EN
                    int'($urandom_range(0, 3)));
`else
                    0);
`endif
            @(posedge clk); #1;
        end
        reset = 1'b0; req_valid = 1'b0;
        repeat (10) @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
